// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the ECP5 PLL bring-up / phase-step controller.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    READY,
    SETUP,
    PULSE,
    GAP
  } state_e;

  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;
  localparam logic [1:0] SEL_CLKOP  = 2'b11;

  localparam int unsigned LANE_W = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync2_bit.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2_bit (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL reset/lock bring-up and dynamic phase-step sequencer.
// Define PLL_PHASE_TRACK_EN to track per-output phase position on phase_pos.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned SETUP_CYCLES        = 2,
  parameter int unsigned PULSE_CYCLES        = 4,
  parameter int unsigned GAP_CYCLES          = 4,
  parameter int unsigned STEPS_W             = 8
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_reset,
  output logic [1:0]         phasesel,
  output logic               phasedir,
  output logic               phasestep,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_sel,
  input  logic               req_dir,
  input  logic [STEPS_W-1:0] req_steps,
  output logic               step_done,
  output logic [7:0]         lock_loss_cnt,
  output logic [31:0]        phase_pos
);

  localparam int unsigned MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_B   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned MAX_C   = (MAX_B > GAP_CYCLES) ? MAX_B : GAP_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned STAB_W  = $clog2(LOCK_STABLE_CYCLES) + 1;

  localparam logic [CNT_W-1:0]  RST_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);

  logic locked;

  sync2_bit u_lock_sync (
    .clk_i (clkin),
    .rst_i (reset),
    .d_i   (pll_locked),
    .q_o   (locked)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic [1:0]         sel_q, sel_d;
  logic               dir_q, dir_d;
  logic               step_q, step_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [7:0]         loss_q, loss_d;
  logic               unlk_q;
  logic               active, lost, enter_rst, enter_pulse;

  assign active = (state_q == READY) || (state_q == SETUP) ||
                  (state_q == PULSE) || (state_q == GAP);
  // Two consecutive unlocked cycles; a single-cycle drop never trips this.
  assign lost   = active && !locked && unlk_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stab_d      = stab_q;
    steps_d     = steps_q;
    sel_d       = sel_q;
    dir_d       = dir_q;
    step_d      = step_q;
    pll_rst_d   = pll_rst_q;
    sys_rst_d   = sys_rst_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    loss_d      = loss_q;
    enter_rst   = 1'b0;
    enter_pulse = 1'b0;

    case (state_q)
      RST_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          pll_rst_d = 1'b0;
          cnt_d     = '0;
          stab_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        stab_d = locked ? stab_q + 1'b1 : '0;
        if (locked && stab_q == STAB_LAST) begin
          state_d   = READY;
          sys_rst_d = 1'b0;
          ready_d   = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == TMO_LAST) begin
          enter_rst = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (req_valid && ready_q) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          steps_d = req_steps;
          if (req_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SETUP;
            ready_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d     = PULSE;
          step_d      = 1'b1;
          cnt_d       = '0;
          enter_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = GAP;
          step_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          steps_d = steps_q - 1'b1;
          if (steps_d == '0) begin
            state_d = READY;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d     = PULSE;
            step_d      = 1'b1;
            enter_pulse = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: enter_rst = 1'b1;
    endcase

    // Lock loss overrides whatever the stepping sequence decided this cycle.
    if (lost) begin
      enter_rst   = 1'b1;
      enter_pulse = 1'b0;
      done_d      = 1'b0;
      loss_d      = sat_inc8(loss_q);
    end

    if (enter_rst) begin
      state_d   = RST_PLL;
      pll_rst_d = 1'b1;
      sys_rst_d = 1'b1;
      ready_d   = 1'b0;
      step_d    = 1'b0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q   <= RST_PLL;
      cnt_q     <= '0;
      stab_q    <= '0;
      steps_q   <= '0;
      sel_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      loss_q    <= '0;
      unlk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      steps_q   <= steps_d;
      sel_q     <= sel_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      loss_q    <= loss_d;
      unlk_q    <= !locked;
    end
  end

`ifdef PLL_PHASE_TRACK_EN
  logic [3:0][LANE_W-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (enter_pulse) begin
      pos_d[sel_q] = pos_q[sel_q] + (dir_q ? LANE_W'(1) : '1);
    end
    if (enter_rst) begin
      pos_d = '0;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign phase_pos = pos_q;
`else
  logic unused_enter_pulse;
  assign unused_enter_pulse = enter_pulse;
  assign phase_pos          = '0;
`endif

  assign pll_rst       = pll_rst_q;
  assign sys_reset     = sys_rst_q;
  assign phasesel      = sel_q;
  assign phasedir      = dir_q;
  assign phasestep     = step_q;
  assign req_ready     = ready_q;
  assign step_done     = done_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboard bench for pll_phase_ctrl with shortened timing parameters.
module tb_pll_phase_ctrl;
  import pll_ctrl_pkg::*;

  localparam int unsigned SW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          pll_locked;
  logic          pll_rst;
  logic          sys_reset;
  logic [1:0]    phasesel;
  logic          phasedir;
  logic          phasestep;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_sel;
  logic          req_dir;
  logic [SW-1:0] req_steps;
  logic          step_done;
  logic [7:0]    lock_loss_cnt;
  logic [31:0]   phase_pos;

  pll_phase_ctrl #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .SETUP_CYCLES        (2),
    .PULSE_CYCLES        (4),
    .GAP_CYCLES          (4),
    .STEPS_W             (SW)
  ) dut (
    .clkin         (clk),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_reset     (sys_reset),
    .phasesel      (phasesel),
    .phasedir      (phasedir),
    .phasestep     (phasestep),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sel       (req_sel),
    .req_dir       (req_dir),
    .req_steps     (req_steps),
    .step_done     (step_done),
    .lock_loss_cnt (lock_loss_cnt),
    .phase_pos     (phase_pos)
  );

  always #20 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] pos;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  int              total  = 0;
  int              passed = 0;
  int              cyc    = 0;
  logic [3:0][7:0] mpos;

  always @(posedge clk) cyc <= cyc + 1;

  // Every step_done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (step_done === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_step_done at cyc=%0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc !== mon_e.cyc || phase_pos !== mon_e.pos)
          $display("FAIL step_done: got cyc=%0d pos=%h, expected cyc=%0d pos=%h",
                   cyc, phase_pos, mon_e.cyc, mon_e.pos);
        else
          passed++;
      end
    end
  end

  initial begin
    #(40 * 50000);
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_apply(input logic [1:0] sel, input logic dir, input int n);
`ifdef PLL_PHASE_TRACK_EN
    mpos[sel] = mpos[sel] + (dir ? 8'(n) : 8'(-n));
`endif
  endtask

  // Leaves the bench at the negedge of the first cycle after reset release.
  task automatic do_reset(input logic lock);
    reset      = 1'b1;
    pll_locked = lock;
    req_valid  = 1'b0;
    req_sel    = '0;
    req_dir    = 1'b0;
    req_steps  = '0;
    step(2);
    reset = 1'b0;
    mpos  = '0;
    sb.delete();
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    total++;
    if ({phasesel, phasedir, phasestep, step_done, req_ready} !== 6'b0 ||
        lock_loss_cnt !== 8'd0 || phase_pos !== 32'd0)
      $display("FAIL reset_outputs: got sel=%b dir=%b step=%b done=%b rdy=%b loss=%0d pos=%h, expected all 0",
               phasesel, phasedir, phasestep, step_done, req_ready, lock_loss_cnt, phase_pos);
    else passed++;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) step(1);
      total++;
      if (pll_rst !== (i < 4)) $display("FAIL bringup_pll_rst c%0d: got %b expected %b", i, pll_rst, i < 4);
      else passed++;
      total++;
      if (sys_reset !== (i < 12)) $display("FAIL bringup_sys_reset c%0d: got %b expected %b", i, sys_reset, i < 12);
      else passed++;
      total++;
      if (req_ready !== (i >= 12)) $display("FAIL bringup_req_ready c%0d: got %b expected %b", i, req_ready, i >= 12);
      else passed++;
    end
  endtask

  task automatic test_timeout;
    do_reset(1'b0);
    for (int i = 0; i < 80; i++) begin
      total++;
      if (pll_rst !== ((i % 36) < 4)) $display("FAIL timeout_pll_rst c%0d: got %b expected %b", i, pll_rst, (i % 36) < 4);
      else passed++;
      total++;
      if (sys_reset !== 1'b1) $display("FAIL timeout_sys_reset c%0d: got %b expected 1", i, sys_reset);
      else passed++;
      step(1);
    end
  endtask

  task automatic bring_up;
    do_reset(1'b1);
    step(12);
  endtask

  task automatic test_steps;
    int t;
    logic exp_step;
    t = cyc;
    req_valid = 1'b1; req_sel = SEL_CLKOS2; req_dir = 1'b1; req_steps = 8'd3;
    model_apply(SEL_CLKOS2, 1'b1, 3);
    sb.push_back('{cyc: t + 27, pos: mpos});
    for (int k = 1; k <= 27; k++) begin
      step(1);
      if (k == 1) req_valid = 1'b0;
      exp_step = (k >= 3) && (k < 27) && (((k - 3) % 8) < 4);
      total++;
      if (phasesel !== SEL_CLKOS2 || phasedir !== 1'b1)
        $display("FAIL steps_sel_dir T+%0d: got %b/%b expected 01/1", k, phasesel, phasedir);
      else passed++;
      total++;
      if (phasestep !== exp_step) $display("FAIL steps_phasestep T+%0d: got %b expected %b", k, phasestep, exp_step);
      else passed++;
      total++;
      if (req_ready !== (k == 27)) $display("FAIL steps_req_ready T+%0d: got %b expected %b", k, req_ready, k == 27);
      else passed++;
    end
    step(1);
    total++;
    if (sb.size() != 0) $display("FAIL steps_pending: got %0d outstanding expected 0", sb.size());
    else passed++;
  endtask

  task automatic test_zero_steps;
    int t;
    t = cyc;
    req_valid = 1'b1; req_sel = SEL_CLKOS3; req_dir = 1'b0; req_steps = 8'd0;
    sb.push_back('{cyc: t + 1, pos: mpos});
    for (int k = 1; k <= 4; k++) begin
      step(1);
      if (k == 1) req_valid = 1'b0;
      total++;
      if (phasestep !== 1'b0 || req_ready !== 1'b1)
        $display("FAIL zero_steps T+%0d: got step=%b rdy=%b expected step=0 rdy=1", k, phasestep, req_ready);
      else passed++;
    end
    total++;
    if (sb.size() != 0) $display("FAIL zero_pending: got %0d outstanding expected 0", sb.size());
    else passed++;
  endtask

  task automatic test_back_to_back;
    int t;
    t = cyc;
    req_valid = 1'b1; req_sel = SEL_CLKOP; req_dir = 1'b0; req_steps = 8'd1;
    model_apply(SEL_CLKOP, 1'b0, 1);
    sb.push_back('{cyc: t + 11, pos: mpos});
    model_apply(SEL_CLKOS, 1'b1, 2);
    sb.push_back('{cyc: t + 30, pos: mpos});
    step(1);
    req_sel = SEL_CLKOS; req_dir = 1'b1; req_steps = 8'd2;
    total++;
    if (req_ready !== 1'b0) $display("FAIL b2b_ready_fall: got %b expected 0", req_ready);
    else passed++;
    step(4);
    total++;
    if (phasesel !== SEL_CLKOP || phasedir !== 1'b0)
      $display("FAIL b2b_ignored_req: got %b/%b expected 11/0", phasesel, phasedir);
    else passed++;
    step(6);
    total++;
    if (req_ready !== 1'b1) $display("FAIL b2b_ready_on_done: got %b expected 1", req_ready);
    else passed++;
    step(1);
    req_valid = 1'b0;
    total++;
    if (req_ready !== 1'b0 || phasesel !== SEL_CLKOS || phasedir !== 1'b1)
      $display("FAIL b2b_second_accept: got rdy=%b sel=%b dir=%b expected 0/00/1", req_ready, phasesel, phasedir);
    else passed++;
    step(19);
    total++;
    if (sb.size() != 0 || req_ready !== 1'b1)
      $display("FAIL b2b_complete: got %0d outstanding rdy=%b expected 0/1", sb.size(), req_ready);
    else passed++;
  endtask

  task automatic test_lock_loss;
    logic [7:0] exp_lane;
`ifdef PLL_PHASE_TRACK_EN
    exp_lane = 8'hFE;
`else
    exp_lane = 8'h00;
`endif
    req_valid = 1'b1; req_sel = SEL_CLKOS3; req_dir = 1'b0; req_steps = 8'd3;
    step(1);
    req_valid = 1'b0;
    step(9);
    pll_locked = 1'b0;
    step(2);
    pll_locked = 1'b1;
    step(1);
    total++;
    if (phasestep !== 1'b1 || sys_reset !== 1'b0 || phase_pos[23:16] !== exp_lane)
      $display("FAIL loss_before: got step=%b sysrst=%b lane2=%h expected 1/0/%h",
               phasestep, sys_reset, phase_pos[23:16], exp_lane);
    else passed++;
    step(1);
    total++;
    if (phasestep !== 1'b0 || sys_reset !== 1'b1 || pll_rst !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL loss_abort: got step=%b sysrst=%b pllrst=%b rdy=%b expected 0/1/1/0",
               phasestep, sys_reset, pll_rst, req_ready);
    else passed++;
    total++;
    if (lock_loss_cnt !== 8'd1 || phase_pos !== 32'd0)
      $display("FAIL loss_count_pos: got cnt=%0d pos=%h expected 1/00000000", lock_loss_cnt, phase_pos);
    else passed++;
    mpos = '0;
    step(11);
    total++;
    if (sys_reset !== 1'b1) $display("FAIL loss_rebringup_early: got %b expected 1", sys_reset);
    else passed++;
    step(1);
    total++;
    if (sys_reset !== 1'b0 || lock_loss_cnt !== 8'd1)
      $display("FAIL loss_rebringup: got sysrst=%b cnt=%0d expected 0/1", sys_reset, lock_loss_cnt);
    else passed++;
  endtask

  task automatic test_glitch;
    step(1);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      total++;
      if (sys_reset !== 1'b0 || req_ready !== 1'b1 || pll_rst !== 1'b0 || lock_loss_cnt !== 8'd1)
        $display("FAIL glitch c%0d: got sysrst=%b rdy=%b pllrst=%b cnt=%0d expected 0/1/0/1",
                 k, sys_reset, req_ready, pll_rst, lock_loss_cnt);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_sel = SEL_CLKOS2; req_dir = 1'b1; req_steps = 8'd2;
    step(1);
    req_valid = 1'b0;
    step(4);
    total++;
    if (phasestep !== 1'b1) $display("FAIL midreset_pulse: got %b expected 1", phasestep);
    else passed++;
    reset = 1'b1;
    step(1);
    total++;
    if (phasestep !== 1'b0 || pll_rst !== 1'b1 || sys_reset !== 1'b1 || req_ready !== 1'b0 ||
        phasesel !== 2'b00 || phasedir !== 1'b0 || lock_loss_cnt !== 8'd0 || phase_pos !== 32'd0)
      $display("FAIL midreset_values: got step=%b pllrst=%b sysrst=%b rdy=%b sel=%b dir=%b cnt=%0d pos=%h",
               phasestep, pll_rst, sys_reset, req_ready, phasesel, phasedir, lock_loss_cnt, phase_pos);
    else passed++;
    reset = 1'b0;
    step(4);
  endtask

  initial begin
    test_reset();
    test_timeout();
    bring_up();
    test_steps();
    test_zero_steps();
    test_back_to_back();
    test_lock_loss();
    test_glitch();
    test_reset_mid();
    total++;
    if (sb.size() != 0) $display("FAIL final_pending: got %0d outstanding expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
Controller for the ECP5 EHXPLLL on ULX3S. It runs the PLL reset/lock bring-up and holds the system reset until lock has been stable long enough. It also sequences dynamic phase-shift requests into PHASESEL/PHASEDIR/PHASESTEP pulses with guaranteed setup, pulse and gap timing. It runs on the 25 MHz board clock, upstream of the PLL, and drives the PLL's RST and phase pins.

Parameters:
RST_PULSE_CYCLES, 16, cycles pll_rst is held high per reset attempt
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release
LOCK_TIMEOUT_CYCLES, 65536, cycles waited for stable lock before retrying the PLL reset
SETUP_CYCLES, 2, cycles phasesel/phasedir are stable before phasestep rises
PULSE_CYCLES, 4, phasestep high time
GAP_CYCLES, 4, phasestep low time after each pulse
STEPS_W, 8, width of the step-count request field

Ports:
clkin  in  1  25 MHz board clock; sole clock of the block
reset  in  1  synchronous, active-high reset
pll_locked  in  1  PLL LOCK; asynchronous to clkin
pll_rst  out  1  to PLL RST
sys_reset  out  1  high while the PLL clocks are not trustworthy
phasesel  out  2  PLL PHASESEL[1:0]: 00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP
phasedir  out  1  PLL PHASEDIR: 1 advance, 0 lag
phasestep  out  1  PLL PHASESTEP
req_valid  in  1  phase-shift request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_sel  in  2  output to shift
req_dir  in  1  direction
req_steps  in  STEPS_W  number of steps (0 allowed)
step_done  out  1  one-cycle pulse when a request completes
lock_loss_cnt  out  8  saturating count of lock losses seen in READY or while stepping
phase_pos  out  32  four 8-bit signed phase positions, CLKOS in [7:0] through CLKOP in [31:24]

Behaviour:
- Reset values:
  - pll_rst=1, sys_reset=1; phasesel, phasedir, phasestep = 0
  - req_ready=0, step_done=0, lock_loss_cnt=0, phase_pos=0
  - state = RST_PLL
- pll_locked passes through a 2-flop synchronizer (reset to 0); "locked" below means the synchronized value.
- State machine:
  - RST_PLL: pll_rst=1 for RST_PULSE_CYCLES, then WAIT_LOCK with pll_rst=0.
  - WAIT_LOCK: a counter counts consecutive locked cycles and clears on any unlocked cycle.
    - Count reaches LOCK_STABLE_CYCLES → READY.
    - LOCK_TIMEOUT_CYCLES elapse in WAIT_LOCK first → RST_PLL.
  - READY: sys_reset=0 and req_ready=1. On handshake, capture sel/dir/steps.
    - steps=0 → step_done next cycle, remain READY.
    - Otherwise → SETUP.
  - SETUP: phasesel/phasedir driven from the cycle after the handshake and held until after the last gap; lasts SETUP_CYCLES → PULSE.
  - PULSE: phasestep=1 for PULSE_CYCLES → GAP.
  - GAP: phasestep=0 for GAP_CYCLES, decrement the remaining count.
    - Count nonzero → PULSE (no repeated setup).
    - Count zero → READY with step_done=1 in that first READY cycle.
- req_ready is low in every state except READY and falls in the cycle after the handshake.
- Lock loss: locked low for 2 consecutive cycles while in READY/SETUP/PULSE/GAP →
  - RST_PLL next cycle; sys_reset=1 that same cycle
  - phasestep forced 0 and the in-flight request aborted with no step_done
  - lock_loss_cnt increments, saturating at 255
- A single-cycle locked drop is ignored.
- Entering RST_PLL clears phase_pos, because the PLL reset restores the static phase.
- reset asserted mid-operation returns all outputs to reset values on the next edge, mid-pulse included.
- Request inputs are ignored while req_ready=0.

Optional Feature:
PLL_PHASE_TRACK_EN
- Defined: at each PULSE entry, phase_pos[sel] changes by +1 when dir=1 and -1 when dir=0, modulo 256 wrap (127+1 → -128).
- Undefined: phase_pos is tied to 0 and no tracking registers exist.

Decomposition:
- Package pll_ctrl_pkg holds:
  - state enum (RST_PLL, WAIT_LOCK, READY, SETUP, PULSE, GAP)
  - PHASESEL encoding constants
  - phase_pos lane width (8)
- One sub-module, sync2_bit, implements the lock synchronizer.
- Timers are in-line counters sized with $clog2 of the largest parameter.

Test Plan:
- Power-up with pll_locked=1 throughout (RST 4, STABLE 8) → pll_rst high cycles 0-3; sys_reset falls exactly 8 cycles after locked is seen synchronized.
- pll_locked held 0 with TIMEOUT=32 → pll_rst re-pulses every 4+32 cycles; sys_reset stays 1.
- Request sel=01, dir=1, steps=3 (SETUP 2, PULSE 4, GAP 4) → phasesel=01 at T+1; 3 pulses of 4 high/4 low starting at T+3; step_done at T+27; with the macro defined, phase_pos[15:8]=3.
- Request steps=0 → step_done at T+1, no phasestep activity, req_ready high again at T+1.
- pll_locked low 2 cycles during the 2nd pulse → phasestep drops, sys_reset=1, lock_loss_cnt=1, no step_done, phase_pos=0.
- Single-cycle pll_locked glitch in READY → no state change; back-to-back requests with req_valid held high → second accepted in the step_done cycle.
